// File: rtl/led_button_frame_engine_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | led_button_frame_engine_if : byte UART link between engine and UART     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface led_button_frame_engine_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy;

  modport master (
    input  rx_byte,
    input  rx_valid,
    input  tx_busy,
    output tx_byte,
    output tx_start
  );

  modport slave (
    output rx_byte,
    output rx_valid,
    output tx_busy,
    input  tx_byte,
    input  tx_start
  );
endinterface
`default_nettype wire

// File: rtl/led_button_frame_engine.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | led_button_frame_engine : header-framed LED/button exchange over UART   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module led_button_frame_engine #(
  parameter int          LED_WIDTH       = 8,
  parameter int          BUTTON_WIDTH    = 24,
  parameter logic [7:0]  HEADER          = 8'hA5,
  parameter logic [31:0] CLKS_PER_SYNC   = 32'd1666666,
  parameter bit          SEND_ON_CHANGE  = 1'b0,
  parameter logic [31:0] RX_TIMEOUT_CLKS = 32'd100000
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [LED_WIDTH-1:0]    leds,
  output logic [BUTTON_WIDTH-1:0] buttons,
  led_button_frame_engine_if.master uart,
  output logic                    frame_sent,
  output logic                    frame_received,
  output logic                    rx_error
);

  localparam int LED_BYTES = (LED_WIDTH + 7) / 8;
  localparam int BTN_BYTES = (BUTTON_WIDTH + 7) / 8;
  localparam int TX_W      = (LED_BYTES + 1) * 8;
  localparam int RX_W      = BTN_BYTES * 8;
  localparam int TIW       = $clog2(LED_BYTES + 1);
  localparam int RIW       = $clog2(BTN_BYTES + 1);

  typedef enum logic [1:0] {T_IDLE, T_SEND, T_HOLD, T_WAIT} tx_state_t;
  typedef enum logic       {R_HUNT, R_DATA} rx_state_t;

  logic [31:0] sync_cnt;
  logic        sync_tick;

  assign sync_tick = (sync_cnt == CLKS_PER_SYNC - 32'd1);

  always_ff @(posedge CLK) begin
    if (!RESET_N)       sync_cnt <= '0;
    else if (sync_tick) sync_cnt <= '0;
    else                sync_cnt <= sync_cnt + 32'd1;
  end

  tx_state_t              tx_state, tx_state_nx;
  logic                   pending, pending_nx;
  logic [LED_WIDTH-1:0]   last_sent, snap;
  logic [TX_W-1:0]        tx_sr;
  logic [TIW-1:0]         tx_idx;
  logic [LED_BYTES*8-1:0] leds_pad;
  logic                   change_req, tx_load, tx_shift, tx_done, tx_start_nx;

  always_comb begin
    leds_pad                = '0;
    leds_pad[LED_WIDTH-1:0] = leds;
    change_req  = SEND_ON_CHANGE && (tx_state == T_IDLE) && (leds != last_sent);
    tx_state_nx = tx_state;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    tx_done     = 1'b0;
    tx_start_nx = 1'b0;
    case (tx_state)
      T_IDLE: if (pending) begin
        tx_load     = 1'b1;
        tx_state_nx = T_SEND;
      end
      T_SEND: if (!uart.tx_busy) begin
        tx_start_nx = 1'b1;
        tx_state_nx = T_HOLD;
      end
      T_HOLD: tx_state_nx = T_WAIT;
      T_WAIT: if (!uart.tx_busy) begin
        if (tx_idx == TIW'(LED_BYTES)) begin
          tx_done     = 1'b1;
          tx_state_nx = T_IDLE;
        end else begin
          tx_shift    = 1'b1;
          tx_state_nx = T_SEND;
        end
      end
      default: tx_state_nx = T_IDLE;
    endcase
    // a change is only a new request when nothing is queued yet
    pending_nx = (pending && !tx_load) || sync_tick || (change_req && !pending);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tx_state      <= T_IDLE;
      pending       <= 1'b0;
      last_sent     <= '0;
      snap          <= '0;
      tx_sr         <= '0;
      tx_idx        <= '0;
      uart.tx_start <= 1'b0;
      uart.tx_byte  <= 8'h00;
      frame_sent    <= 1'b0;
    end else begin
      tx_state      <= tx_state_nx;
      pending       <= pending_nx;
      uart.tx_start <= tx_start_nx;
      frame_sent    <= tx_done;
      if (tx_load) begin
        snap   <= leds;
        tx_sr  <= {leds_pad, HEADER};
        tx_idx <= '0;
      end
      if (tx_start_nx) uart.tx_byte <= tx_sr[7:0];
      if (tx_shift) begin
        tx_sr  <= tx_sr >> 8;
        tx_idx <= tx_idx + TIW'(1);
      end
      if (tx_done) last_sent <= snap;
    end
  end

  rx_state_t       rx_state, rx_state_nx;
  logic [RIW-1:0]  rx_idx;
  logic [RX_W-1:0] rx_sr;
  logic [RX_W+7:0] rx_cat;
  logic [31:0]     to_cnt;
  logic            rx_begin, rx_accept, rx_complete, rx_timeout;

  // new byte enters at the top so the first payload byte ends up least significant
  assign rx_cat = {uart.rx_byte, rx_sr} >> 8;

  always_comb begin
    rx_state_nx = rx_state;
    rx_begin    = 1'b0;
    rx_accept   = 1'b0;
    rx_complete = 1'b0;
    rx_timeout  = 1'b0;
    case (rx_state)
      R_HUNT: if (uart.rx_valid && (uart.rx_byte == HEADER)) begin
        rx_begin    = 1'b1;
        rx_state_nx = R_DATA;
      end
      R_DATA: if (uart.rx_valid) begin
        rx_accept = 1'b1;
        if (rx_idx == RIW'(BTN_BYTES - 1)) begin
          rx_complete = 1'b1;
          rx_state_nx = R_HUNT;
        end
      end else if (to_cnt >= RX_TIMEOUT_CLKS) begin
        rx_timeout  = 1'b1;
        rx_state_nx = R_HUNT;
      end
      default: rx_state_nx = R_HUNT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rx_state       <= R_HUNT;
      rx_idx         <= '0;
      rx_sr          <= '0;
      to_cnt         <= '0;
      buttons        <= '0;
      frame_received <= 1'b0;
      rx_error       <= 1'b0;
    end else begin
      rx_state       <= rx_state_nx;
      frame_received <= rx_complete;
      rx_error       <= rx_timeout;
      if (rx_begin) begin
        rx_idx <= '0;
        to_cnt <= '0;
      end else if (rx_accept) begin
        rx_sr  <= rx_cat[RX_W-1:0];
        rx_idx <= rx_idx + RIW'(1);
        to_cnt <= '0;
      end else if (rx_state == R_DATA) begin
        to_cnt <= to_cnt + 32'd1;
      end
      if (rx_complete) buttons <= rx_cat[BUTTON_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_button_frame_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_led_button_frame_engine : scoreboard bench, two engine configurations |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_led_button_frame_engine;

  typedef struct {
    bit          err;
    logic [23:0] val;
  } rx_exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [7:0]  leds_a = 8'h00;
  logic [9:0]  leds_b = 10'h000;
  logic [23:0] btn_a;
  logic [11:0] btn_b;
  logic        fs_a, fr_a, er_a, fs_b, fr_b, er_b;

  int vectors = 0;
  int miscompares = 0;
  int busy_a = 0, busy_b = 0;
  int fs_cnt_a = 0, ev_a = 0, ev_b = 0;
  int push_a = 0, push_b = 0;

  logic [7:0] exp_tx_a[$];
  logic [7:0] exp_tx_b[$];
  rx_exp_t    exp_rx_a[$];
  rx_exp_t    exp_rx_b[$];

  always #5 CLK = ~CLK;

  led_button_frame_engine_if ifa();
  led_button_frame_engine_if ifb();

  led_button_frame_engine #(
    .CLKS_PER_SYNC(32'd20), .RX_TIMEOUT_CLKS(32'd40)
  ) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .leds(leds_a), .buttons(btn_a), .uart(ifa),
    .frame_sent(fs_a), .frame_received(fr_a), .rx_error(er_a)
  );

  led_button_frame_engine #(
    .LED_WIDTH(10), .BUTTON_WIDTH(12), .CLKS_PER_SYNC(32'd200),
    .SEND_ON_CHANGE(1'b1), .RX_TIMEOUT_CLKS(32'd40)
  ) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .leds(leds_b), .buttons(btn_b), .uart(ifb),
    .frame_sent(fs_b), .frame_received(fr_b), .rx_error(er_b)
  );

  // UART TX models: busy for 10 cycles after each accepted start
  always @(posedge CLK) begin
    if (!RESET_N) begin
      busy_a <= 0;
      busy_b <= 0;
    end else begin
      if (ifa.tx_start)     busy_a <= 10;
      else if (busy_a != 0) busy_a <= busy_a - 1;
      if (ifb.tx_start)     busy_b <= 10;
      else if (busy_b != 0) busy_b <= busy_b - 1;
    end
  end
  assign ifa.tx_busy = (busy_a != 0);
  assign ifb.tx_busy = (busy_b != 0);

  always @(posedge CLK) begin
    if (fs_a)        fs_cnt_a <= fs_cnt_a + 1;
    if (fr_a || er_a) ev_a    <= ev_a + 1;
    if (fr_b || er_b) ev_b    <= ev_b + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_tx(input bit sel, input int max_wait, output logic [7:0] b, output bit got);
    got = 1'b0;
    b   = 8'h00;
    for (int i = 0; i < max_wait; i++) begin
      @(posedge CLK);
      #1;
      if (sel ? ifb.tx_start : ifa.tx_start) begin
        got = 1'b1;
        b   = sel ? ifb.tx_byte : ifa.tx_byte;
        break;
      end
    end
  endtask

  task automatic tx_expect(input bit sel, input int max_wait);
    logic [7:0] b, e;
    bit got;
    e = 8'h00;
    wait_tx(sel, max_wait, b, got);
    chk("tx_seen", got, 1);
    if (sel) begin
      chk("tx_sb_nonempty", exp_tx_b.size() != 0, 1);
      if (exp_tx_b.size() != 0) e = exp_tx_b.pop_front();
    end else begin
      chk("tx_sb_nonempty", exp_tx_a.size() != 0, 1);
      if (exp_tx_a.size() != 0) e = exp_tx_a.pop_front();
    end
    chk("tx_byte", b, e);
  endtask

  task automatic rx_send(input bit sel, input logic [7:0] b);
    if (sel) begin
      ifb.rx_byte  = b;
      ifb.rx_valid = 1'b1;
    end else begin
      ifa.rx_byte  = b;
      ifa.rx_valid = 1'b1;
    end
    @(posedge CLK);
    #1;
    ifa.rx_valid = 1'b0;
    ifb.rx_valid = 1'b0;
  endtask

  // bytes sent least-significant first, ends one sample after the last byte
  task automatic rx_seq(input bit sel, input logic [63:0] seq, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      rx_send(sel, seq[8*i +: 8]);
      if (i < n - 1) cyc(gap);
    end
  endtask

  task automatic rx_expect(input bit sel, input bit err, input logic [23:0] val);
    rx_exp_t e;
    e.err = err;
    e.val = val;
    if (sel) begin
      exp_rx_b.push_back(e);
      push_b++;
    end else begin
      exp_rx_a.push_back(e);
      push_a++;
    end
  endtask

  task automatic rx_check(input bit sel, input int max_wait);
    int          waited;
    rx_exp_t     e;
    logic        ev;
    logic        err;
    logic [23:0] btn;
    waited = 0;
    e.err  = 1'b0;
    e.val  = 24'h0;
    ev = sel ? (fr_b | er_b) : (fr_a | er_a);
    while (!ev && waited < max_wait) begin
      cyc(1);
      waited++;
      ev = sel ? (fr_b | er_b) : (fr_a | er_a);
    end
    chk("rx_event", ev, 1);
    err = sel ? er_b : er_a;
    btn = sel ? {12'h000, btn_b} : btn_a;
    if (sel) begin
      chk("rx_sb_nonempty", exp_rx_b.size() != 0, 1);
      if (exp_rx_b.size() != 0) e = exp_rx_b.pop_front();
    end else begin
      chk("rx_sb_nonempty", exp_rx_a.size() != 0, 1);
      if (exp_rx_a.size() != 0) e = exp_rx_a.pop_front();
    end
    chk("rx_kind_err", err, e.err);
    chk("buttons", btn, e.val);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_btn_a"}, btn_a, 0);
    chk({tag, "_btn_b"}, btn_b, 0);
    chk({tag, "_txs_a"}, ifa.tx_start, 0);
    chk({tag, "_txs_b"}, ifb.tx_start, 0);
    chk({tag, "_txb_a"}, ifa.tx_byte, 0);
    chk({tag, "_txb_b"}, ifb.tx_byte, 0);
    chk({tag, "_flags_a"}, {fs_a, fr_a, er_a}, 0);
    chk({tag, "_flags_b"}, {fs_b, fr_b, er_b}, 0);
  endtask

  initial begin
    logic [7:0] b;
    bit         got;
    int         fs_before;
    int         waited;

    ifa.rx_byte = 8'h00; ifa.rx_valid = 1'b0;
    ifb.rx_byte = 8'h00; ifb.rx_valid = 1'b0;
    leds_a = 8'h3C;
    leds_b = 10'h000;

    // reset state
    RESET_N = 1'b0;
    cyc(3);
    chk_all_zero("reset");

    // periodic TX on A: A5,3C per frame, one frame_sent each
    for (int f = 0; f < 3; f++) begin
      exp_tx_a.push_back(8'hA5);
      exp_tx_a.push_back(8'h3C);
    end
    fs_before = fs_cnt_a;
    RESET_N = 1'b1;
    for (int i = 0; i < 6; i++) tx_expect(1'b0, 60);
    waited = 0;
    while (!fs_a && waited < 30) begin
      cyc(1);
      waited++;
    end
    cyc(1);
    chk("frame_sent_count", fs_cnt_a - fs_before, 3);

    // RX on B, 12-bit buttons: high nibble of F2 dropped
    rx_expect(1'b1, 1'b0, 24'h000234);
    rx_seq(1'b1, 64'hF2_34_A5, 3, 2);
    rx_check(1'b1, 0);
    cyc(1);
    chk("fr_pulse_width", fr_b, 0);
    chk("buttons_hold_b", btn_b, 12'h234);

    // inter-byte gaps under the timeout still complete
    rx_expect(1'b1, 1'b0, 24'h000C5A);
    rx_seq(1'b1, 64'h0C_5A_A5, 3, 30);
    rx_check(1'b1, 0);

    // hunt skips junk, header value inside payload is data
    rx_expect(1'b0, 1'b0, 24'h07A501);
    rx_seq(1'b0, 64'h07_A5_01_A5_11, 5, 2);
    rx_check(1'b0, 0);

    // timeout aborts the frame, buttons untouched
    rx_expect(1'b0, 1'b1, 24'h07A501);
    rx_seq(1'b0, 64'h01_A5, 2, 2);
    rx_check(1'b0, 100);
    cyc(3);
    rx_expect(1'b0, 1'b0, 24'hCCBBAA);
    rx_seq(1'b0, 64'hCC_BB_AA_A5, 4, 2);
    rx_check(1'b0, 0);

    // reset in the middle of RX frames and a TX frame
    rx_seq(1'b0, 64'h11_A5, 2, 1);
    rx_send(1'b1, 8'hA5);
    wait_tx(1'b0, 60, b, got);
    chk("mid_tx_seen", got, 1);
    cyc(2);
    RESET_N = 1'b0;
    cyc(1);
    chk_all_zero("midreset");
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("tx_start_in_reset_a", ifa.tx_start, 0);
      chk("tx_start_in_reset_b", ifb.tx_start, 0);
    end
    RESET_N = 1'b1;
    cyc(1);
    rx_seq(1'b0, 64'h33_22, 2, 1);
    rx_seq(1'b1, 64'hF2_34, 2, 1);
    cyc(2);
    chk("btn_a_after_reset", btn_a, 0);
    chk("btn_b_after_reset", btn_b, 0);
    rx_expect(1'b0, 1'b0, 24'h030201);
    rx_seq(1'b0, 64'h03_02_01_A5, 4, 2);
    rx_check(1'b0, 0);

    // send-on-change on B: snapshot protects the frame in flight
    exp_tx_b.push_back(8'hA5);
    exp_tx_b.push_back(8'h00);
    exp_tx_b.push_back(8'h00);
    tx_expect(1'b1, 300);
    leds_b = 10'h3FF;
    tx_expect(1'b1, 30);
    tx_expect(1'b1, 30);
    exp_tx_b.push_back(8'hA5);
    exp_tx_b.push_back(8'hFF);
    exp_tx_b.push_back(8'h03);
    tx_expect(1'b1, 40);
    tx_expect(1'b1, 30);
    tx_expect(1'b1, 30);
    wait_tx(1'b1, 80, b, got);
    chk("no_extra_frame", got, 0);

    cyc(2);
    chk("rx_events_a", ev_a, push_a);
    chk("rx_events_b", ev_b, push_b);
    chk("rx_sb_left", exp_rx_a.size() + exp_rx_b.size(), 0);
    chk("tx_sb_left", exp_tx_a.size() + exp_tx_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
